// File: rtl/data_format_adapter_ram_reader.sv
// Read-side controller for the lookahead buffer RAM: tracks occupancy, issues
// reads, and hides the 1-cycle RAM read latency behind a 2-entry skid FIFO.
module data_format_adapter_ram_reader #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_commit,
  input  logic                     wr_waitrequest,
  output logic [ADDRESS_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0]    rd_readdata,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow
);

  localparam logic [ADDRESS_WIDTH:0] LEVEL_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [ADDRESS_WIDTH-1:0] rd_address_q, rd_address_d;
  logic [ADDRESS_WIDTH:0]   unread_q, unread_d;
  logic [ADDRESS_WIDTH:0]   level_q, level_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               skid_cnt_q, skid_cnt_d;
  logic [DATA_WIDTH-1:0]    skid_head_q, skid_head_d;
  logic [DATA_WIDTH-1:0]    skid_tail_q, skid_tail_d;
  logic                     overflow_q, overflow_d;

  logic       pop;
  logic       commit_ok;
  logic       commit_drop;
  logic       issue;
  logic [1:0] occ;

  always_comb begin
    pop         = (skid_cnt_q != 2'd0) && out_ready;
    commit_ok   = wr_commit && !wr_waitrequest && ((level_q != LEVEL_FULL) || pop);
    commit_drop = wr_commit && !wr_waitrequest && (level_q == LEVEL_FULL) && !pop;
    // Words held or arriving next cycle, after this cycle's pop; keeps skid <= 2.
    occ         = skid_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    issue       = !wr_waitrequest && (unread_q != '0) && (occ < 2'd2);
  end

  always_comb begin
    rd_address_d = rd_address_q;
    unread_d     = unread_q;
    level_d      = level_q;
    inflight_d   = issue;
    overflow_d   = overflow_q | commit_drop;

    if (issue) begin
      rd_address_d = rd_address_q + ADDRESS_WIDTH'(1);
    end

    case ({commit_ok, issue})
      2'b10:   unread_d = unread_q + (ADDRESS_WIDTH+1)'(1);
      2'b01:   unread_d = unread_q - (ADDRESS_WIDTH+1)'(1);
      default: unread_d = unread_q;
    endcase

    case ({commit_ok, pop})
      2'b10:   level_d = level_q + (ADDRESS_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDRESS_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    skid_cnt_d  = skid_cnt_q;
    skid_head_d = skid_head_q;
    skid_tail_d = skid_tail_q;

    if (inflight_q && pop) begin
      // Capture and pop together: head advances, new word lands behind it.
      if (skid_cnt_q == 2'd2) begin
        skid_head_d = skid_tail_q;
        skid_tail_d = rd_readdata;
      end else begin
        skid_head_d = rd_readdata;
      end
    end else if (inflight_q) begin
      if (skid_cnt_q == 2'd0) begin
        skid_head_d = rd_readdata;
      end else begin
        skid_tail_d = rd_readdata;
      end
      skid_cnt_d = skid_cnt_q + 2'd1;
    end else if (pop) begin
      skid_head_d = skid_tail_q;
      skid_cnt_d  = skid_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_address_q <= '0;
      unread_q     <= '0;
      level_q      <= '0;
      inflight_q   <= 1'b0;
      skid_cnt_q   <= '0;
      skid_head_q  <= '0;
      skid_tail_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      rd_address_q <= rd_address_d;
      unread_q     <= unread_d;
      level_q      <= level_d;
      inflight_q   <= inflight_d;
      skid_cnt_q   <= skid_cnt_d;
      skid_head_q  <= skid_head_d;
      skid_tail_q  <= skid_tail_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rd_address = rd_address_q;
  assign out_data   = skid_head_q;
  assign out_valid  = (skid_cnt_q != 2'd0);
  assign level      = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_data_format_adapter_ram_reader.sv
// Scoreboard bench for data_format_adapter_ram_reader with a behavioural
// lookahead RAM; the writer pushes expected words, a monitor checks transfers.
module tb_data_format_adapter_ram_reader;

  logic       clk;
  logic       reset_n;
  logic       wr_commit;
  logic       wr_waitrequest;
  logic [3:0] rd_address;
  logic [7:0] rd_readdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       overflow;

  logic [7:0] mem [16];
  logic       ram_we;
  logic [3:0] ram_wa;
  logic [7:0] ram_wd;
  logic [3:0] wp;
  logic [3:0] addr_of [256];
  logic [7:0] exp_q [$];

  int errors;
  int checks;

  data_format_adapter_ram_reader #(
    .DATA_WIDTH(8),
    .ADDRESS_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_commit(wr_commit),
    .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address),
    .rd_readdata(rd_readdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_readdata <= mem[rd_address];
    if (ram_we) mem[ram_wa] <= ram_wd;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got %02h expected no transfer", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL stream_data: got %02h expected %02h", out_data, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic [7:0] d, input bit acc);
    wr_commit = 1'b1;
    if (acc) begin
      ram_we = 1'b1;
      ram_wa = wp;
      ram_wd = d;
      exp_q.push_back(d);
      addr_of[d] = wp;
      wp = wp + 4'd1;
    end else begin
      ram_we = 1'b0;
    end
  endtask

  task automatic clr_commit;
    wr_commit = 1'b0;
    ram_we    = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int k = 0; k < 80 && !(exp_q.size() == 0 && level == 5'd0); k++) tick();
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("drain_level", int'(level), 0);
    check("drain_rdaddr", int'(rd_address), int'(wp));
    tick();
  endtask

  initial begin
    int first, last, cnt, wraps;
    logic [3:0] prev, diff;
    logic [7:0] held;

    errors = 0; checks = 0;
    reset_n = 1'b0; wr_commit = 1'b0; wr_waitrequest = 1'b0; out_ready = 1'b0;
    ram_we = 1'b0; ram_wa = '0; ram_wd = '0; wp = '0;

    // Reset state
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_level", int'(level), 0);
    check("rst_rdaddr", int'(rd_address), 0);
    check("rst_overflow", int'(overflow), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single word: 3-cycle latency
    out_ready = 1'b1;
    set_commit(8'hA5, 1);
    @(negedge clk);
    check("single_n0_valid", int'(out_valid), 0);
    tick(); clr_commit();
    @(negedge clk);
    check("single_n1_level", int'(level), 1);
    check("single_n1_valid", int'(out_valid), 0);
    tick();
    @(negedge clk);
    check("single_n2_valid", int'(out_valid), 0);
    tick();
    @(negedge clk);
    check("single_n3_valid", int'(out_valid), 1);
    check("single_n3_data", int'(out_data), 8'hA5);
    tick();
    @(negedge clk);
    check("single_level_after", int'(level), 0);
    tick();

    // Streaming 40 words
    out_ready = 1'b1;
    first = -1; last = -1; cnt = 0; wraps = 0; prev = rd_address;
    for (int i = 0; i < 48; i++) begin
      if (i < 40) set_commit(8'(i), 1); else clr_commit();
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = i;
        cnt++;
        last = i;
      end
      if (prev == 4'd15 && rd_address == 4'd0) wraps++;
      prev = rd_address;
      tick();
    end
    clr_commit();
    check("stream_first", first, 3);
    check("stream_count", cnt, 40);
    check("stream_last", last, 42);
    check("stream_wraps", wraps, 2);
    drain();

    // Backpressure for 10 cycles mid-stream
    held = '0;
    for (int i = 0; i < 50; i++) begin
      if (i < 30) set_commit(8'(100 + i), 1); else clr_commit();
      out_ready = !(i >= 12 && i < 22);
      @(negedge clk);
      if (i >= 12 && i < 22) begin
        check("bp_valid", int'(out_valid), 1);
        if (i == 12) held = out_data;
        else check("bp_stable", int'(out_data), int'(held));
        if (i == 21) begin
          diff = rd_address - addr_of[out_data];
          check("bp_issue_depth", int'(diff <= 4'd2), 1);
        end
      end
      tick();
    end
    clr_commit();
    drain();

    // Full / overflow
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_commit(8'(200 + i), 1);
      tick();
    end
    clr_commit();
    repeat (3) tick();
    @(negedge clk);
    check("full_level", int'(level), 16);
    check("full_overflow", int'(overflow), 0);
    tick();
    out_ready = 1'b1;
    set_commit(8'd216, 1);
    tick();
    out_ready = 1'b0;
    clr_commit();
    @(negedge clk);
    check("full_pop_level", int'(level), 16);
    check("full_pop_overflow", int'(overflow), 0);
    tick();
    set_commit(8'd217, 0);
    tick();
    clr_commit();
    @(negedge clk);
    check("ovf_set", int'(overflow), 1);
    check("ovf_level", int'(level), 16);
    tick();
    drain();
    check("ovf_sticky", int'(overflow), 1);

    // Waitrequest with 3 unread words
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_commit(8'(50 + i), 1);
      tick();
    end
    clr_commit();
    wr_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_commit(8'd99, 0);
      @(negedge clk);
      check("wreq_rdaddr", int'(rd_address), int'(wp - 4'd3));
      check("wreq_level", int'(level), 5);
      tick();
    end
    wr_waitrequest = 1'b0;
    clr_commit();
    drain();

    // Reset mid-stream with skid full
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_commit(8'(150 + i), 1);
      tick();
    end
    clr_commit();
    repeat (2) tick();
    @(negedge clk);
    check("midrst_pre_valid", int'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_data", int'(out_data), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_rdaddr", int'(rd_address), 0);
    check("midrst_overflow", int'(overflow), 0);
    exp_q.delete();
    wp = '0;
    tick(); tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
      tick();
    end
    check("midrst_no_stale", cnt, 0);
    set_commit(8'h3C, 1);
    tick();
    clr_commit();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
